// File: rtl/db_tupu_ram_sp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : db_tupu_ram_sp_ctrl
// Brief    : Parametrised single-port TU/PU info RAM controller for deblocking.
//            Self-clearing sweep after reset or on request, bit-masked partial
//            writes via internal read-modify-write, ready/valid client side.
// Revision : 1.0 - initial release
// ============================================================================
module db_tupu_ram_sp_ctrl #(
    parameter int              DW      = 32,
    parameter int              AW      = 6,
    parameter logic [DW-1:0]   CLR_VAL = {DW{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    output logic            clr_busy_o,
    output logic            rdy_o,
    input  logic            cen_i,
    input  logic            wen_i,
    input  logic [AW-1:0]   adr_i,
    input  logic [DW-1:0]   msk_i,
    input  logic [DW-1:0]   wr_dat_i,
    output logic [DW-1:0]   rd_dat_o,
    output logic            rd_vld_o
);

    localparam int         c_DEPTH     = 1 << AW;

    localparam logic [1:0] c_ST_CLEAR  = 2'd0;
    localparam logic [1:0] c_ST_IDLE   = 2'd1;
    localparam logic [1:0] c_ST_RMW_WR = 2'd2;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;

    logic [AW-1:0]  r_clr_cnt;

    // Partial-write context captured when the RMW read is issued
    logic [AW-1:0]  r_rmw_adr;
    logic [DW-1:0]  r_rmw_dat;
    logic [DW-1:0]  r_rmw_msk;
    logic [DW-1:0]  r_rmw_word;

    // Storage array; contents are only defined after a completed clear sweep
    logic [DW-1:0]  r_mem [c_DEPTH];

    logic [DW-1:0]  r_rd_dat;
    logic           r_rd_vld;

    // ------------------------------------------------------------------------
    // Client-side decode
    // ------------------------------------------------------------------------
    logic           w_rdy;
    logic           w_acc;
    logic           w_acc_rd;
    logic           w_acc_wr_full;
    logic           w_acc_wr_part;
    logic           w_msk_full;
    logic           w_clr_last;
    logic [DW-1:0]  w_rmw_merge;

    // Single array port controls, driven by the output process
    logic           w_mem_we;
    logic [AW-1:0]  w_mem_adr;
    logic [DW-1:0]  w_mem_wdat;
    logic           w_clr_busy;

    // A clear request in IDLE wins over any access presented in the same cycle
    assign w_rdy         = (r_state == c_ST_IDLE) && !clr_i;
    assign w_acc         = !cen_i && w_rdy;
    assign w_msk_full    = &msk_i;
    assign w_acc_rd      = w_acc &&  wen_i;
    assign w_acc_wr_full = w_acc && !wen_i &&  w_msk_full;
    // An all-zero mask still goes through the RMW path and rewrites old data
    assign w_acc_wr_part = w_acc && !wen_i && !w_msk_full;

    assign w_clr_last    = &r_clr_cnt;

    // Keep stored bits where the mask is 0, take new data where it is 1
    assign w_rmw_merge   = (r_rmw_word & ~r_rmw_msk) | (r_rmw_dat & r_rmw_msk);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // Reset drops any in-flight RMW and restarts the clear sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // Sweep ends after the last address; partial writes take one extra cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_CLEAR: begin
                if (w_clr_last) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_IDLE: begin
                if (clr_i) begin
                    w_state_nxt = c_ST_CLEAR;
                end else if (w_acc_wr_part) begin
                    w_state_nxt = c_ST_RMW_WR;
                end
            end
            c_ST_RMW_WR: begin
                // clr_i is deliberately not looked at here; IDLE re-samples it
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic (array write port and status)
    // ------------------------------------------------------------------------
    // Select who owns the single array write port in each state
    always_comb begin
        w_clr_busy = 1'b0;
        w_mem_we   = 1'b0;
        w_mem_adr  = adr_i;
        w_mem_wdat = wr_dat_i;
        case (r_state)
            c_ST_CLEAR: begin
                w_clr_busy = 1'b1;
                w_mem_we   = 1'b1;
                w_mem_adr  = r_clr_cnt;
                w_mem_wdat = CLR_VAL;
            end
            c_ST_IDLE: begin
                w_mem_we   = w_acc_wr_full;
            end
            c_ST_RMW_WR: begin
                w_mem_we   = 1'b1;
                w_mem_adr  = r_rmw_adr;
                w_mem_wdat = w_rmw_merge;
            end
            default: begin
                w_clr_busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Clear sweep address counter
    // ------------------------------------------------------------------------
    // Walks every address once; wraps to zero as the sweep completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_cnt <= '0;
        end else if (r_state == c_ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + AW'(1);
        end else if ((r_state == c_ST_IDLE) && clr_i) begin
            r_clr_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Partial-write context capture (RMW read happens here)
    // ------------------------------------------------------------------------
    // Latch address, data, mask and the old word for the merge cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rmw_adr  <= '0;
            r_rmw_dat  <= '0;
            r_rmw_msk  <= '0;
            r_rmw_word <= '0;
        end else if (w_acc_wr_part) begin
            r_rmw_adr  <= adr_i;
            r_rmw_dat  <= wr_dat_i;
            r_rmw_msk  <= msk_i;
            r_rmw_word <= r_mem[adr_i];
        end
    end

    // ------------------------------------------------------------------------
    // Client read path
    // ------------------------------------------------------------------------
    // Registered read data holds until the next accepted client read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_dat <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= w_acc_rd;
            if (w_acc_rd) begin
                r_rd_dat <= r_mem[adr_i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Storage array write port
    // ------------------------------------------------------------------------
    // Behavioural single-port storage; no reset, the sweep defines contents
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_adr] <= w_mem_wdat;
        end
    end

    assign rdy_o      = w_rdy;
    assign clr_busy_o = w_clr_busy;
    assign rd_dat_o   = r_rd_dat;
    assign rd_vld_o   = r_rd_vld;

endmodule

`default_nettype wire

// File: tb/tb_db_tupu_ram_sp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_db_tupu_ram_sp_ctrl
// Brief    : Self-checking bench for db_tupu_ram_sp_ctrl with a word-array
//            reference model, directed steps and randomized accesses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_db_tupu_ram_sp_ctrl;

    localparam int            DW      = 32;
    localparam int            AW      = 6;
    localparam int            DEPTH   = 1 << AW;
    localparam logic [DW-1:0] CLR_VAL = '0;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clr_i = 1'b0;
    logic            cen_i = 1'b1;
    logic            wen_i = 1'b1;
    logic [AW-1:0]   adr_i = '0;
    logic [DW-1:0]   msk_i = '0;
    logic [DW-1:0]   wr_dat_i = '0;
    logic            clr_busy_o;
    logic            rdy_o;
    logic [DW-1:0]   rd_dat_o;
    logic            rd_vld_o;

    int              checks = 0;
    int              errors = 0;

    // Reference model: plain word array plus the expected held read value
    logic [DW-1:0]   model [DEPTH];
    logic [DW-1:0]   exp_rd = '0;

    db_tupu_ram_sp_ctrl #(
        .DW      (DW),
        .AW      (AW),
        .CLR_VAL (CLR_VAL)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr_i),
        .clr_busy_o (clr_busy_o),
        .rdy_o      (rdy_o),
        .cen_i      (cen_i),
        .wen_i      (wen_i),
        .adr_i      (adr_i),
        .msk_i      (msk_i),
        .wr_dat_i   (wr_dat_i),
        .rd_dat_o   (rd_dat_o),
        .rd_vld_o   (rd_vld_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        cen_i = 1'b1;
        wen_i = 1'b1;
        clr_i = 1'b0;
    endtask

    // Count busy cycles of a sweep that has just started; model becomes CLR_VAL
    task automatic sweep_count(input string tag);
        int n = 0;
        logic rdy_seen = 1'b0;
        while (clr_busy_o === 1'b1 && n < 200) begin
            if (rdy_o !== 1'b0) rdy_seen = 1'b1;
            tick();
            n++;
        end
        check({tag, "_sweep_len"}, 64'(n), 64'(DEPTH));
        check({tag, "_rdy_low_in_sweep"}, {63'd0, rdy_seen}, 64'd0);
        check({tag, "_rdy_after_sweep"}, {63'd0, rdy_o}, 64'd1);
        for (int i = 0; i < DEPTH; i++) model[i] = CLR_VAL;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   {63'd0, clr_busy_o}, 64'd1);
        check({tag, "_rdy"},    {63'd0, rdy_o},      64'd0);
        check({tag, "_vld"},    {63'd0, rd_vld_o},   64'd0);
        check({tag, "_rddat"},  64'(rd_dat_o),       64'd0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input string tag);
        cen_i = 1'b0;
        wen_i = 1'b1;
        adr_i = a;
        #1;
        check({tag, "_rdy"}, {63'd0, rdy_o}, 64'd1);
        tick();
        idle_in();
        exp_rd = model[a];
        check({tag, "_vld"}, {63'd0, rd_vld_o}, 64'd1);
        check({tag, "_data"}, 64'(rd_dat_o), 64'(exp_rd));
        tick();
        check({tag, "_vld_drop"}, {63'd0, rd_vld_o}, 64'd0);
        check({tag, "_hold"}, 64'(rd_dat_o), 64'(exp_rd));
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW-1:0] m, input string tag);
        cen_i    = 1'b0;
        wen_i    = 1'b0;
        adr_i    = a;
        wr_dat_i = d;
        msk_i    = m;
        #1;
        check({tag, "_rdy"}, {63'd0, rdy_o}, 64'd1);
        tick();
        idle_in();
        model[a] = (model[a] & ~m) | (d & m);
        #1;
        if (m != {DW{1'b1}}) begin
            check({tag, "_rmw_rdy_low"}, {63'd0, rdy_o}, 64'd0);
            check({tag, "_rmw_no_vld"}, {63'd0, rd_vld_o}, 64'd0);
            check({tag, "_rmw_rddat_hold"}, 64'(rd_dat_o), 64'(exp_rd));
            tick();
            check({tag, "_rmw_rdy_back"}, {63'd0, rdy_o}, 64'd1);
            check({tag, "_rmw_no_vld2"}, {63'd0, rd_vld_o}, 64'd0);
        end else begin
            check({tag, "_full_rdy"}, {63'd0, rdy_o}, 64'd1);
            check({tag, "_full_no_vld"}, {63'd0, rd_vld_o}, 64'd0);
        end
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] m;
        logic [AW-1:0] a;
        int op;

        for (int i = 0; i < DEPTH; i++) model[i] = 'x;

        // Power-on reset and first clear sweep
        idle_in();
        repeat (3) tick();
        check_reset_outputs("por");
        rst_n = 1'b1;
        sweep_count("por");
        do_read(6'd63, "por_rd63");
        check("por_rd63_lit", 64'(rd_dat_o), 64'h0);
        do_read(6'd0, "por_rd0");

        // Full write then read back
        do_write(6'd5, 32'h12345678, 32'hFFFFFFFF, "full_wr5");
        do_read(6'd5, "full_rd5");
        check("full_rd5_lit", 64'(rd_dat_o), 64'h12345678);

        // Partial write merges the low half
        do_write(6'd5, 32'hAABBCCDD, 32'h0000FFFF, "part_wr5");
        do_read(6'd5, "part_rd5");
        check("part_rd5_lit", 64'(rd_dat_o), 64'h1234CCDD);

        // All-zero mask still costs an RMW cycle and changes nothing
        do_write(6'd5, 32'hFFFFFFFF, 32'h00000000, "zmsk_wr5");
        do_read(6'd5, "zmsk_rd5");
        check("zmsk_rd5_lit", 64'(rd_dat_o), 64'h1234CCDD);

        // Read held through the RMW cycle is ignored, then accepted in IDLE
        do_write(6'd10, 32'hCAFEF00D, 32'hFFFFFFFF, "hold_pre");
        cen_i = 1'b0; wen_i = 1'b0; adr_i = 6'd10;
        wr_dat_i = 32'h00000000; msk_i = 32'hFF00FF00;
        #1;
        check("hold_wr_rdy", {63'd0, rdy_o}, 64'd1);
        tick();
        model[10] = (model[10] & ~32'hFF00FF00) | (32'h0 & 32'hFF00FF00);
        wen_i = 1'b1;
        #1;
        check("hold_rmw_rdy", {63'd0, rdy_o}, 64'd0);
        tick();
        check("hold_ignored_vld", {63'd0, rd_vld_o}, 64'd0);
        check("hold_idle_rdy", {63'd0, rdy_o}, 64'd1);
        tick();
        idle_in();
        exp_rd = model[10];
        check("hold_rd_vld", {63'd0, rd_vld_o}, 64'd1);
        check("hold_rd_data", 64'(rd_dat_o), 64'h00FE000D);

        // Back-to-back reads
        do_write(6'd1, 32'h11, 32'hFFFFFFFF, "b2b_w1");
        do_write(6'd2, 32'h22, 32'hFFFFFFFF, "b2b_w2");
        do_write(6'd3, 32'h33, 32'hFFFFFFFF, "b2b_w3");
        cen_i = 1'b0; wen_i = 1'b1; adr_i = 6'd1;
        tick();
        adr_i = 6'd2;
        check("b2b_vld1", {63'd0, rd_vld_o}, 64'd1);
        check("b2b_dat1", 64'(rd_dat_o), 64'h11);
        tick();
        adr_i = 6'd3;
        check("b2b_vld2", {63'd0, rd_vld_o}, 64'd1);
        check("b2b_dat2", 64'(rd_dat_o), 64'h22);
        tick();
        idle_in();
        check("b2b_vld3", {63'd0, rd_vld_o}, 64'd1);
        check("b2b_dat3", 64'(rd_dat_o), 64'h33);
        tick();
        exp_rd = 32'h33;
        check("b2b_vld_drop", {63'd0, rd_vld_o}, 64'd0);
        check("b2b_hold", 64'(rd_dat_o), 64'h33);

        // Randomized accesses against the model
        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), $urandom, 32'hFFFFFFFF, "rnd_init");
        for (int it = 0; it < 150; it++) begin
            op = int'($urandom_range(0, 3));
            a  = AW'($urandom_range(0, DEPTH - 1));
            d  = $urandom;
            m  = $urandom;
            case (op)
                0: do_read(a, "rnd_rd");
                1: do_write(a, d, 32'hFFFFFFFF, "rnd_full");
                2: begin
                    if ($urandom_range(0, 7) == 0) m = '0;
                    if (m == {DW{1'b1}}) m[0] = 1'b0;
                    do_write(a, d, m, "rnd_part");
                end
                default: begin
                    tick();
                    check("rnd_idle_vld", {63'd0, rd_vld_o}, 64'd0);
                    check("rnd_idle_hold", 64'(rd_dat_o), 64'(exp_rd));
                end
            endcase
        end

        // Clear has priority over a same-cycle write
        do_write(6'd7, 32'h0BADBEEF, 32'hFFFFFFFF, "clr_pre");
        clr_i = 1'b1; cen_i = 1'b0; wen_i = 1'b0; adr_i = 6'd7;
        wr_dat_i = 32'hFFFFFFFF; msk_i = 32'hFFFFFFFF;
        #1;
        check("clr_req_rdy", {63'd0, rdy_o}, 64'd0);
        tick();
        idle_in();
        sweep_count("clr");
        do_read(6'd7, "clr_rd7");
        check("clr_rd7_lit", 64'(rd_dat_o), 64'(CLR_VAL));

        // Reset during the RMW write cycle
        do_write(6'd9, 32'h55555555, 32'hFFFFFFFF, "rst_pre");
        do_read(6'd9, "rst_pre_rd");
        cen_i = 1'b0; wen_i = 1'b0; adr_i = 6'd9;
        wr_dat_i = 32'hFFFFFFFF; msk_i = 32'h000000FF;
        tick();
        idle_in();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rmw_rst");
        tick();
        tick();
        rst_n = 1'b1;
        exp_rd = '0;
        sweep_count("rmw_rst");
        do_read(6'd9, "rmw_rst_rd9");
        check("rmw_rst_rd9_lit", 64'(rd_dat_o), 64'(CLR_VAL));

        // Reset in the middle of a clear sweep restarts a full sweep
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("clr_rst");
        tick();
        rst_n = 1'b1;
        sweep_count("clr_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/db_tupu_ram_sp_ctrl.md
Name: db_tupu_ram_sp_ctrl

Overview:
- Parametrised successor to the fixed 64x32 single-port TU/PU info RAM used by deblocking.
- Generalised in data width and depth, with three behaviours the fixed RAM lacks:
  - self-clearing initialisation after reset or on request;
  - bit-masked partial writes, done as an internal read-modify-write over the single port;
  - a ready/valid indication on the client side.
- Sits between the deblocking TU/PU boundary-info writers/readers and the single-port storage array.

Parameters:
- DW, 32, data word width in bits.
- AW, 6, address width; depth is fixed at 2**AW entries.
- CLR_VAL, {DW{1'b0}}, value written to every entry during a clear sweep.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr_i  input  1  clear request; sampled only in IDLE.
- clr_busy_o  output  1  high while a clear sweep runs.
- rdy_o  output  1  block can accept an access this cycle.
- cen_i  input  1  access request, low active.
- wen_i  input  1  1 = read, 0 = write (low active, as on the existing RAMs).
- adr_i  input  AW  access address.
- msk_i  input  DW  write bit mask; 1 = replace bit with wr_dat_i, 0 = keep stored bit.
- wr_dat_i  input  DW  write data.
- rd_dat_o  output  DW  read data (registered).
- rd_vld_o  output  1  one-cycle pulse: rd_dat_o carries new read data.

Behaviour:
- Storage: behavioural single-port array, synchronous read, one array access per cycle.
- Accept condition: cen_i==0 && rdy_o==1.
- rdy_o (combinational) = (state==IDLE) && !clr_i.
- States:
  - CLEAR: clear counter walks 0..2**AW-1, one CLR_VAL write per cycle.
    - clr_busy_o=1, rdy_o=0.
    - After writing the last address: state -> IDLE, clr_busy_o drops in the next cycle.
    - Sweep length is exactly 2**AW cycles.
  - IDLE:
    - clr_i=1: go to CLEAR with counter=0. Any request in the same cycle is not accepted (clear has priority).
    - Accepted read: array read issued; next cycle rd_dat_o=mem[adr], rd_vld_o=1. Stay IDLE; back-to-back reads give 1 result per cycle.
    - Accepted write, msk_i all ones: single-cycle write of wr_dat_i; stay IDLE.
    - Accepted write, partial mask (any zero bit): array read issued at adr_i; adr, wr_dat and msk are registered; go to RMW_WR.
  - RMW_WR:
    - Write (rd_word & ~msk) | (wr_dat & msk) to the registered address.
    - rdy_o=0, rd_vld_o=0, rd_dat_o unchanged. RMW reads never pulse rd_vld_o.
    - Next state: IDLE.
    - Cost: partial write occupies exactly 2 cycles, with rdy_o low for exactly 1.
    - clr_i is ignored here and re-sampled in IDLE.
- rd_dat_o holds its last read value until the next accepted read.
- A read accepted in the cycle after a write to the same address returns the written (merged) data; no bypass is needed.
- Mask all zeros is a partial write: it still performs the RMW and leaves data unchanged.
- Reset (asynchronous, any time, including mid-RMW or mid-clear):
  - state=CLEAR, counter=0, clr_busy_o=1, rdy_o=0, rd_dat_o=0, rd_vld_o=0.
  - Any in-flight RMW write is dropped.
  - Array contents are defined (CLR_VAL) only once the sweep completes.
- Requests presented while rdy_o=0 are ignored; the requester must hold them until accepted.

Test Plan:
- Reset clear, defaults DW=32/AW=6: release rst_n -> clr_busy_o=1 and rdy_o=0 for exactly 64 cycles; then read addr 63 and addr 0 -> 0x00000000 each, rd_vld_o pulse one cycle after accept.
- Full write/read: write addr 5 = 0x12345678, mask 0xFFFFFFFF -> rdy_o stays 1; next-cycle read of addr 5 -> rd_dat_o=0x12345678 one cycle later.
- Partial write: addr 5 holds 0x12345678; write 0xAABBCCDD with mask 0x0000FFFF -> rdy_o=0 for exactly 1 cycle, no rd_vld_o; then read addr 5 -> 0x1234CCDD.
- Back-to-back reads of addr 1, 2, 3 (holding 0x11, 0x22, 0x33) on consecutive cycles -> rd_vld_o high 3 consecutive cycles with data 0x11, 0x22, 0x33; rd_dat_o holds 0x33 afterwards.
- Clear vs request: in IDLE assert clr_i and a write (addr 7, data 0xFFFFFFFF, full mask) in the same cycle -> write not accepted; clr_busy_o=1 for 64 cycles; then read addr 7 -> CLR_VAL.
- Reset mid-RMW: assert rst_n=0 during RMW_WR -> outputs reset immediately; after release, full 64-cycle clear runs and the target address reads CLR_VAL.
